// File: rtl/mse_window_acc_pkg.sv
// Shared constants for the MER/MSE windowed squared-error accumulator.
package mse_window_acc_pkg;

  localparam int LFSR_LEN = 4;
  localparam int DEF_W    = 18;

  // Accumulator width: one error word plus one bit per doubling of the window.
  function automatic int acc_w(input int w, input int l);
    return w + l;
  endfunction

endpackage

// File: rtl/mse_window_acc_sq_trunc_acc.sv
// One channel: square and truncate the error, then accumulate it with saturation.
module sq_trunc_acc #(
  parameter int W     = 18,
  parameter int ACC_W = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             smp_en,
  input  logic             acc_en,
  input  logic             acc_last,
  input  logic [W-1:0]     err,
  output logic [ACC_W-1:0] nxt_o,
  output logic             nxt_sat_o
);

  logic signed [W-1:0]   err_s;
  logic signed [2*W-1:0] sq;
  logic [W-1:0]          t_d, t_q;
  logic [ACC_W:0]        sum;
  logic [ACC_W-1:0]      acc_d, acc_q;
  logic                  sat_d, sat_q;
  logic                  sq_unused;

  assign err_s = err;
  assign sq    = err_s * err_s;
  // Kept unsigned: (-1.0)^2 lands on bit W-1 and must read as +1.0.
  assign t_d       = sq[2*W-2:W-1];
  assign sq_unused = ^{sq[2*W-1], sq[W-2:0]};

  assign sum       = {1'b0, acc_q} + {{(ACC_W+1-W){1'b0}}, t_q};
  assign nxt_o     = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  assign nxt_sat_o = sat_q | sum[ACC_W];

  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (clear) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (acc_en) begin
      acc_d = acc_last ? '0 : nxt_o;
      sat_d = acc_last ? 1'b0 : nxt_sat_o;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_q   <= '0;
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      if (smp_en) t_q <= t_d;
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

endmodule

// File: rtl/mse_window_acc.sv
// Multi-channel windowed squared-error accumulator with a registered valid/ready result port.
module mse_window_acc
  import mse_window_acc_pkg::*;
#(
  parameter int  W        = DEF_W,
  parameter int  N_CH     = 2,
  parameter int  WIN_LOG2 = LFSR_LEN,
  localparam int ACC_W    = acc_w(W, WIN_LOG2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  clear,
  input  logic                  use_ext_hold,
  input  logic                  hold,
  input  logic [N_CH*W-1:0]     err,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [N_CH*W-1:0]     mse_out,
  output logic [N_CH*ACC_W-1:0] acc_full_out,
  output logic [N_CH-1:0]       sat_out,
  output logic                  overrun
);

  logic [WIN_LOG2-1:0]          cnt_d, cnt_q;
  logic                         s1_vld_d, s1_vld_q;
  logic                         s1_last_d, s1_last_q;
  logic                         out_valid_d, out_valid_q;
  logic                         overrun_d, overrun_q;
  logic [N_CH-1:0][W-1:0]       mse_d, mse_q;
  logic [N_CH-1:0][ACC_W-1:0]   full_d, full_q;
  logic [N_CH-1:0]              sat_d, sat_q;
  logic [N_CH-1:0][ACC_W-1:0]   nxt;
  logic [N_CH-1:0]              nxt_sat;
  logic                         win_end;

  // A pending last sample is dropped if clear arrives alongside it.
  assign win_end = s1_vld_q & s1_last_q & ~clear;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    sq_trunc_acc #(.W(W), .ACC_W(ACC_W)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .smp_en    (clk_en),
      .acc_en    (s1_vld_q),
      .acc_last  (s1_last_q),
      .err       (err[c*W +: W]),
      .nxt_o     (nxt[c]),
      .nxt_sat_o (nxt_sat[c])
    );
  end

  always_comb begin
    cnt_d       = cnt_q;
    s1_vld_d    = clk_en & ~clear;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    mse_d       = mse_q;
    full_d      = full_q;
    sat_d       = sat_q;

    if (clk_en) s1_last_d = use_ext_hold ? hold : (cnt_q == {WIN_LOG2{1'b1}});

    if (clear || use_ext_hold) cnt_d = '0;
    else if (clk_en)           cnt_d = cnt_q + 1'b1;

    if (win_end) begin
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) overrun_d = 1'b1;
      full_d = nxt;
      sat_d  = nxt_sat;
      for (int c = 0; c < N_CH; c++) mse_d[c] = nxt[c][ACC_W-1:WIN_LOG2];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      mse_q       <= '0;
      full_q      <= '0;
      sat_q       <= '0;
    end else begin
      cnt_q       <= cnt_d;
      s1_vld_q    <= s1_vld_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      mse_q       <= mse_d;
      full_q      <= full_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign overrun      = overrun_q;
  assign mse_out      = mse_q;
  assign acc_full_out = full_q;
  assign sat_out      = sat_q;

endmodule

// File: tb/tb_mse_window_acc.sv
// Bench for mse_window_acc: directed window table, corner sequences, random run against a window model.
module tb_mse_window_acc;

  localparam int     W      = 18;
  localparam int     N_CH   = 2;
  localparam int     WL     = 4;
  localparam int     ACC_W  = 22;
  localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1, clk_en = 1'b0, clear = 1'b0;
  logic                  use_ext_hold = 1'b0, hold = 1'b0, out_ready = 1'b0;
  logic [N_CH*W-1:0]     err = '0;
  logic                  out_valid, overrun;
  logic [N_CH*W-1:0]     mse_out;
  logic [N_CH*ACC_W-1:0] acc_full_out;
  logic [N_CH-1:0]       sat_out;

  always #5 clk = ~clk;

  mse_window_acc #(.W(W), .N_CH(N_CH), .WIN_LOG2(WL)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .clear(clear),
    .use_ext_hold(use_ext_hold), .hold(hold), .err(err), .out_ready(out_ready),
    .out_valid(out_valid), .mse_out(mse_out), .acc_full_out(acc_full_out),
    .sat_out(sat_out), .overrun(overrun)
  );

  int n_chk = 0;
  int n_err = 0;

  // Window model: running per-channel sums, a one-sample pipeline delay, and the result port.
  longint m_sum[N_CH];
  bit     m_sat[N_CH];
  int     m_cnt;
  bit     m_pend, m_pend_last;
  longint m_pend_t[N_CH];
  bit     e_valid, e_ovr;
  longint e_full[N_CH];
  bit     e_sat[N_CH];

  function automatic longint trunc_sq(input logic [W-1:0] e);
    longint v;
    v = $signed(e);
    return (v * v) >> (W - 1);
  endfunction

  task automatic model_step();
    bit closing;
    longint s;
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        m_sum[c] = 0; m_sat[c] = 0; e_full[c] = 0; e_sat[c] = 0;
      end
      m_cnt = 0; m_pend = 0; m_pend_last = 0; e_valid = 0; e_ovr = 0;
      return;
    end
    closing = 0;
    if (!clear && m_pend) begin
      for (int c = 0; c < N_CH; c++) begin
        s = m_sum[c] + m_pend_t[c];
        if (s > ACC_MAX) begin s = ACC_MAX; m_sat[c] = 1; end
        if (m_pend_last) begin
          e_full[c] = s; e_sat[c] = m_sat[c]; m_sum[c] = 0; m_sat[c] = 0;
        end else begin
          m_sum[c] = s;
        end
      end
      closing = m_pend_last;
    end
    if (closing) begin
      if (e_valid && !out_ready) e_ovr = 1;
      e_valid = 1;
    end else if (out_ready) begin
      e_valid = 0;
    end
    if (clear) begin
      for (int c = 0; c < N_CH; c++) begin m_sum[c] = 0; m_sat[c] = 0; end
      m_cnt = 0; m_pend = 0;
    end else begin
      m_pend = clk_en;
      if (clk_en) begin
        for (int c = 0; c < N_CH; c++) m_pend_t[c] = trunc_sq(err[c*W +: W]);
        m_pend_last = use_ext_hold ? hold : (m_cnt == (1 << WL) - 1);
      end
      if (use_ext_hold) m_cnt = 0;
      else if (clk_en) m_cnt = (m_cnt + 1) % (1 << WL);
    end
  endtask

  task automatic chk(input string nm, input int ch, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s ch%0d at %0t: got %0d expected %0d", nm, ch, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("model_out_valid", 0, longint'(out_valid), longint'(e_valid));
    chk("model_overrun", 0, longint'(overrun), longint'(e_ovr));
    for (int c = 0; c < N_CH; c++) begin
      chk("model_full", c, longint'(acc_full_out[c*ACC_W +: ACC_W]), e_full[c]);
      chk("model_mse", c, longint'(mse_out[c*W +: W]), e_full[c] >> WL);
      chk("model_sat", c, longint'(sat_out[c]), longint'(e_sat[c]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic drive(input bit en, input logic [W-1:0] e0, input logic [W-1:0] e1, input bit h);
    clk_en = en;
    err    = {e1, e0};
    hold   = h;
  endtask

  task automatic run_window(input int n, input logic [W-1:0] e0, input logic [W-1:0] e1);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, e0, e1, use_ext_hold && (i == n - 1));
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("accept_clears_valid", 0, longint'(out_valid), 0);
  endtask

  typedef struct {
    bit          ext;
    int          n;
    logic [W-1:0] e0, e1;
    longint      f0, f1, m0, m1;
    logic [1:0]  sat;
  } vec_t;

  vec_t vecs[4];
  int   early;

  initial begin
    vecs[0] = '{0, 16, 18'h08000, 18'h20000, 131072, 2097152, 8192, 131072, 2'b00};
    vecs[1] = '{1, 33, 18'h00000, 18'h20000, 0, 4194303, 0, 262143, 2'b10};
    vecs[2] = '{0, 16, 18'h00001, 18'h00400, 0, 128, 0, 8, 2'b00};
    vecs[3] = '{1, 5, 18'h1FFFF, 18'h3FFFF, 655350, 0, 40959, 0, 2'b00};

    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", 0, longint'(out_valid), 0);
    chk("rst_full", 0, longint'(acc_full_out), 0);
    chk("rst_overrun", 0, longint'(overrun), 0);

    for (int v = 0; v < 4; v++) begin
      use_ext_hold = vecs[v].ext;
      run_window(vecs[v].n, vecs[v].e0, vecs[v].e1);
      chk("tbl_not_yet_valid", v, longint'(out_valid), 0);
      tick();
      chk("tbl_valid", v, longint'(out_valid), 1);
      chk("tbl_full0", v, longint'(acc_full_out[0 +: ACC_W]), vecs[v].f0);
      chk("tbl_full1", v, longint'(acc_full_out[ACC_W +: ACC_W]), vecs[v].f1);
      chk("tbl_mse0", v, longint'(mse_out[0 +: W]), vecs[v].m0);
      chk("tbl_mse1", v, longint'(mse_out[W +: W]), vecs[v].m1);
      chk("tbl_sat", v, longint'(sat_out), longint'(vecs[v].sat));
      accept();
    end
    use_ext_hold = 1'b0;

    // Accept on the same edge a new result lands: stays valid, no overrun.
    run_window(16, 18'h08000, 18'h00000);
    tick();
    run_window(16, 18'h04000, 18'h00000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("land_valid", 0, longint'(out_valid), 1);
    chk("land_overrun", 0, longint'(overrun), 0);
    chk("land_full0", 0, longint'(acc_full_out[0 +: ACC_W]), 32768);

    // Second unconsumed window overwrites and flags overrun.
    run_window(16, 18'h08000, 18'h00000);
    tick();
    chk("ovr_flag", 0, longint'(overrun), 1);
    chk("ovr_full0", 0, longint'(acc_full_out[0 +: ACC_W]), 131072);

    // Reset mid-window with a pending result.
    run_window(5, 18'h08000, 18'h20000);
    drive(1'b1, 18'h08000, 18'h20000, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    chk("rst_mid_valid", 0, longint'(out_valid), 0);
    chk("rst_mid_overrun", 0, longint'(overrun), 0);
    chk("rst_mid_full", 0, longint'(acc_full_out), 0);
    chk("rst_mid_mse", 0, longint'(mse_out), 0);
    run_window(16, 18'h08000, 18'h00000);
    chk("rst_next_not_yet", 0, longint'(out_valid), 0);
    tick();
    chk("rst_next_full0", 0, longint'(acc_full_out[0 +: ACC_W]), 131072);
    accept();

    // Clear after 7 samples, with a sample on the clear edge that must be dropped.
    run_window(7, 18'h08000, 18'h20000);
    drive(1'b1, 18'h08000, 18'h20000, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    early = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 18'h08000, 18'h20000, 1'b0);
      tick();
      if (out_valid) early++;
    end
    drive(1'b0, '0, '0, 1'b0);
    chk("clr_no_early", 0, longint'(early), 0);
    tick();
    chk("clr_valid", 0, longint'(out_valid), 1);
    chk("clr_mse0", 0, longint'(mse_out[0 +: W]), 8192);
    chk("clr_mse1", 1, longint'(mse_out[W +: W]), 131072);
    accept();

    // Randomised run against the model.
    for (int i = 0; i < 1500; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      clear     = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 79) == 0) use_ext_hold = ~use_ext_hold;
      hold      = ($urandom_range(0, 11) == 0);
      clk_en    = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < N_CH; c++) begin
        case ($urandom_range(0, 3))
          0:       err[c*W +: W] = 18'h20000;
          1:       err[c*W +: W] = 18'h1FFFF;
          default: err[c*W +: W] = W'($urandom);
        endcase
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mse_window_acc.md
# mse_window_acc

Multi-channel windowed squared-error accumulator for the demodulator's MER/MSE measurement path. Each enabled sample, it squares N_CH signed slicer-error words, truncates them to the 1s17-style fraction, accumulates them per channel over a window and presents per-window mean-square and full sums through a valid/ready result port. The window is closed either by an internal 2^WIN_LOG2 sample counter or by an external `hold` strobe. It sits after the slicer error outputs and feeds the measurement/readout logic.

## Interface
- `W`, 18: error word width, signed, format 1s(W-1).
- `N_CH`, 2: number of channels, e.g. I and Q.
- `WIN_LOG2`, 4: log2 of the window length in internal mode; also the right-shift applied to form the mean. Production value is `LFSR_LEN.
- `ACC_W`, W+WIN_LOG2: accumulator width, unsigned (derived constant).
- `clk` in 1: clock, single domain.
- `reset` in 1: synchronous, active-high; clears all state.
- `clk_en` in 1: sample strobe; `err` is valid when high.
- `clear` in 1: synchronous; discards the partial window.
- `use_ext_hold` in 1: 1 = window closed by `hold`; 0 = internal counter.
- `hold` in 1: qualified by `clk_en`; marks the current sample as the last of its window.
- `err` in N_CH*W: packed signed errors; channel c occupies bits [c*W +: W].
- `out_ready` in 1: consumer accepts the result.
- `out_valid` out 1: result registers hold an unconsumed window.
- `mse_out` out N_CH*W: per channel, unsigned acc[ACC_W-1:WIN_LOG2].
- `acc_full_out` out N_CH*ACC_W: per-channel full window sums.
- `sat_out` out N_CH: per channel, the accumulator saturated in this window.
- `overrun` out 1: sticky; a result was overwritten before it was consumed.

## Operation
- Square and truncate: sq = err_c*err_c (2W bits). The truncated square is t = sq[2W-2:W-1], treated as **unsigned** W bits and zero-extended. An input of -2^(W-1) therefore yields 2^(W-1) and must not become negative.
- Stage 1: on `clk_en`, register t for every channel, set s1_vld and set the s1_last tag.
  - Internal mode: last = (cnt == 2^WIN_LOG2-1).
  - External mode: last = `hold`.
- Counter `cnt` (WIN_LOG2 bits):
  - Increments per accepted sample and wraps to 0 after the last sample.
  - Held at 0 while `use_ext_hold`=1.
- Stage 2, when s1_vld: nxt = acc + t, saturating at 2^ACC_W-1. Saturation sets the channel's sat bit.
  - s1_last=0: acc <= nxt.
  - s1_last=1: load the result registers with nxt and the sat bits, then clear acc and sat to 0 and set `out_valid`.
- Handshake:
  - `out_valid` clears on a cycle with `out_valid && out_ready`.
  - A new result arriving in the same cycle as an accept overwrites the old one, `out_valid` stays 1, and this is not an overrun.
  - A new result arriving while `out_valid && !out_ready` overwrites the old one and sets `overrun`.
- `clear`: zeroes acc, sat, cnt and s1_vld; result registers, `out_valid` and `overrun` are untouched. When `clear` and `clk_en` occur together, the sample is discarded.
- `reset`: every register and output goes to 0, including `overrun`. `overrun` clears only on `reset`.
- Changing `use_ext_hold` mid-window: the partial sum continues; the counter restarts from 0 when internal mode resumes.

## Timing
- Sample accepted at edge E: square registered at E, accumulated at E+1.
- Last sample at edge E: `out_valid`, `mse_out`, `acc_full_out` and `sat_out` are valid after E+1, a 2-clock latency.
- Stage 2 advances on s1_vld independently of `clk_en`, so back-to-back `clk_en` samples are sustained at full rate.
- The result port is registered; there is no combinational path from `out_ready` to any output.

## Structure
- Shared package / `defines.vh`: `LFSR_LEN, the default W, and a `ACC_W(W,L) width macro.
- Sub-module `sq_trunc_acc`: one channel's squarer, truncation, saturating accumulator and sat bit. It is instantiated N_CH times in a generate loop.
- The top level holds the counter, last-tag logic, result registers and handshake.

## Test plan
Configuration: W=18, N_CH=2, WIN_LOG2=4.
- Internal mode, 16 samples of ch0=0x08000, ch1=0x20000 (-1.0) -> `mse_out` ch0=8192 and ch1=131072; `acc_full_out` 131072 and 2097152; `out_valid` asserted 2 clocks after the 16th sample.
- External mode with `hold` never asserted, ch1=-1.0 for 32 samples, then `hold` -> ch1 `acc_full_out`=4194303 with `sat_out`[1]=1.
- Hold `out_ready`=0 through two windows -> `overrun`=1, and the second window's values are presented.
- `clear` pulsed after 7 samples, then 16 samples of 0x08000 -> mean 8192; no window closes early.
- `out_ready` high on the cycle a new result lands -> `out_valid` stays 1 and `overrun` stays 0.
- `reset` mid-window with `out_valid`=1 -> all outputs 0 on the next clock, and the next window is counted from sample 0.
